imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have one clock, clk_i; the reset, rst_i, SHALL be synchronous and active-high.
REQ-002 Ports SHALL be as follows:
- clk_i, input, 1: clock.
- rst_i, input, 1: synchronous active-high reset.
- in_valid_i, input, 1: field bundle valid.
- in_ready_o, output, 1: block accepts the bundle this cycle.
- opcode_i, input, 7: instruction opcode.
- rd_i, input, 5: rd field.
- rs1_i, input, 5: rs1 field.
- rs2_i, input, 5: rs2 field.
- funct3_i, input, 3: funct3 field.
- funct7_i, input, 7: funct7 field.
- imm_i, input, 32: signed byte immediate.
- out_valid_o, output, 1: inst_o valid.
- out_ready_i, input, 1: consumer takes inst_o.
- inst_o, output, 32: packed instruction word.
- err_o, output, 1: sticky error flag.
- count_o, output, 16: count of emitted words.

Function
REQ-003 Transfers SHALL use valid/ready: an input is accepted when in_valid_i and in_ready_o are both high; an output is consumed when out_valid_o and out_ready_i are both high.
REQ-004 Accepted bundles SHALL be packed into a 2-entry FIFO; in_ready_o SHALL equal "FIFO not full" and SHALL not depend on out_ready_i.
REQ-005 Latency SHALL be 1 cycle: a bundle accepted into an empty FIFO SHALL appear on inst_o with out_valid_o high the next cycle.
REQ-006 Words SHALL emerge in acceptance order.
REQ-007 Simultaneous push and pop SHALL be legal at occupancy 1; occupancy SHALL be unchanged, and the new word SHALL become the head after the pop.
REQ-008 Full FIFO: no push SHALL occur. Empty FIFO: out_valid_o SHALL be 0 and inst_o SHALL hold 0.
REQ-009 Each opcode SHALL be packed as follows:
- 0110011 (R-type): funct7 at [31:25], rs2 at [24:20], rs1 at [19:15], funct3 at [14:12], rd at [11:7], opcode at [6:0].
- 0010011 and 0000011 (I-type): imm[11:0] at [31:20], rs1, funct3, rd, opcode.
- 0100011 (S-type): imm[11:5] at [31:25], rs2, rs1, funct3, imm[4:0] at [11:7], opcode.
- 1100011 (B-type): imm[12] at [31], imm[10:5] at [30:25], rs2, rs1, funct3, imm[4:1] at [11:8], imm[11] at [7], opcode.
REQ-010 An unsupported opcode SHALL be accepted but not enqueued, and SHALL set err_o.
REQ-011 count_o SHALL increment by 1 on each output pop and SHALL saturate at 0xFFFF.
REQ-012 err_o SHALL be sticky once set, until reset.

Reset
REQ-013 While rst_i is high at a clk_i edge, the block SHALL:
- empty the FIFO,
- drive out_valid_o=0, inst_o=0, err_o=0, count_o=0,
- drive in_ready_o=1 from the following cycle.
REQ-014 Reset mid-operation SHALL discard any queued words, and no partial output SHALL follow.

Configuration
REQ-015 With IMM_RANGE_CHECK_EN defined, the block SHALL range-check immediates:
- I/S-type: imm_i SHALL be within [-2048, 2047].
- B-type: imm_i SHALL be within [-4096, 4094] with imm_i[0]=0.
- A violating bundle SHALL be accepted, dropped (not enqueued) and SHALL set err_o.
REQ-016 Without IMM_RANGE_CHECK_EN, immediates SHALL be truncated to the encoded bits, unchecked; err_o SHALL be set only per REQ-010.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- opcode 0010011, rd=1, rs1=0, funct3=0, imm=5, out_ready_i=1 -> inst_o=0x00500093 one cycle later, count_o=1.
- opcode 0100011, rs1=1, rs2=2, funct3=010, imm=8 -> inst_o=0x0020A423.
- opcode 1100011, rs1=0, rs2=0, funct3=0, imm=-4 -> inst_o=0xFE000EE3.
- out_ready_i=0, three back-to-back bundles -> in_ready_o=0 after 2 accepts; third held; releasing out_ready_i drains all three in order.
- opcode 0000000 -> nothing emitted, err_o=1 and stays 1; rst_i pulse -> err_o=0, count_o=0, FIFO empty.
- IMM_RANGE_CHECK_EN defined, I-type imm=2048 -> dropped, err_o=1; undefined -> inst_o[31:20]=0x800.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs RISC-V instruction fields (R/I/S/B formats) into 32-bit words
// and queues them in a 2-entry FIFO with valid/ready handshakes on both sides.
// Bundles with an unsupported opcode are accepted, dropped and raise a sticky err_o.
// count_o counts emitted words and saturates at 0xFFFF.
// Optional feature: define IMM_RANGE_CHECK_EN to drop (and flag) bundles whose
// immediate does not fit the encoded field; otherwise immediates are truncated.
module imm_encoder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] inst_o,
    output logic        err_o,
    output logic [15:0] count_o
);

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpS    = 7'b0100011;
    localparam logic [6:0] OpB    = 7'b1100011;

    logic [31:0] enc_word;
    logic        enc_ok;
    logic        range_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        bad;

    logic [31:0] mem_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  occ_q, occ_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;

    // Upper immediate bits only matter to the optional range check.
    logic unused_imm;
    assign unused_imm = ^imm_i[31:13];

    // Pack the field bundle according to the opcode's instruction format.
    always_comb begin
        enc_word = 32'h0;
        enc_ok   = 1'b1;
        unique case (opcode_i)
            OpR:
                enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            OpImm, OpLoad:
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            OpS:
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            OpB:
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
            default:
                enc_ok = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must fit the signed field of its format; branch offsets must be even.
    always_comb begin
        range_ok = 1'b1;
        if (opcode_i == OpImm || opcode_i == OpLoad || opcode_i == OpS) begin
            range_ok = ($signed(imm_i) >= -32'sd2048) && ($signed(imm_i) <= 32'sd2047);
        end else if (opcode_i == OpB) begin
            range_ok = ($signed(imm_i) >= -32'sd4096) && ($signed(imm_i) <= 32'sd4094) &&
                       !imm_i[0];
        end
    end
`else
    // Immediates are truncated to the encoded bits without checking.
    always_comb begin
        range_ok = 1'b1;
    end
`endif

    assign in_ready_o  = (occ_q != 2'd2);
    assign out_valid_o = (occ_q != 2'd0);
    assign inst_o      = out_valid_o ? mem_q[rd_ptr_q] : 32'h0;
    assign err_o       = err_q;
    assign count_o     = count_q;

    assign accept = in_valid_i && in_ready_o;
    assign push   = accept && enc_ok && range_ok;
    assign bad    = accept && !(enc_ok && range_ok);
    assign pop    = out_valid_o && out_ready_i;

    // Next-state for FIFO pointers/occupancy, emitted-word counter and error flag.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        count_d  = count_q;
        err_d    = err_q | bad;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
        end
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            count_q  <= 16'h0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset; occupancy gates what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder; expected words are hand-encoded constants.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        err;
    logic [15:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    imm_encoder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .opcode_i    (opcode),
        .rd_i        (rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .imm_i       (imm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .inst_o      (inst),
        .err_o       (err),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] im);
        in_valid = 1'b1;
        opcode   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
        imm      = im;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_count", {16'b0, count}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // I-type addi x1, x0, 5
        out_ready = 1'b1;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick(); in_valid = 1'b0;
        check("i_valid", {31'b0, out_valid}, 32'd1);
        check("i_inst", inst, 32'h00500093);
        tick();
        check("i_count", {16'b0, count}, 32'd1);
        check("i_empty_inst", inst, 32'h0);
        check("i_empty_valid", {31'b0, out_valid}, 32'd0);

        // S-type sw x2, 8(x1)
        drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        tick(); in_valid = 1'b0;
        check("s_inst", inst, 32'h0020A423);
        tick();
        check("s_count", {16'b0, count}, 32'd2);

        // B-type beq x0, x0, -4
        drive(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        tick(); in_valid = 1'b0;
        check("b_inst", inst, 32'hFE000EE3);
        tick();

        // R-type sub x3, x1, x2
        drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
        tick(); in_valid = 1'b0;
        check("r_inst", inst, 32'h402081B3);
        tick();

        // Load lw x5, -1(x6)
        drive(7'b0000011, 5'd5, 5'd6, 5'd0, 3'b010, 7'd0, 32'hFFFF_FFFF);
        tick(); in_valid = 1'b0;
        check("ld_inst", inst, 32'hFFF32283);
        tick();
        check("ld_count", {16'b0, count}, 32'd5);

        // Backpressure: three back-to-back bundles with consumer stalled
        out_ready = 1'b0;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tick();
        check("bp_ready_after1", {31'b0, in_ready}, 32'd1);
        drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        tick();
        check("bp_ready_after2", {31'b0, in_ready}, 32'd0);
        drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        tick();
        check("bp_held_ready", {31'b0, in_ready}, 32'd0);
        check("bp_head_a", inst, 32'h00100093);
        out_ready = 1'b1;
        tick();
        check("bp_head_b", inst, 32'h00200113);
        check("bp_ready_reopen", {31'b0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0;
        // Third bundle pushed while B popped at occupancy 1
        check("bp_head_c", inst, 32'h00300193);
        check("bp_valid_c", {31'b0, out_valid}, 32'd1);
        tick();
        check("bp_drained", {31'b0, out_valid}, 32'd0);
        check("bp_count", {16'b0, count}, 32'd8);

        // I-type immediate 2048: out of range for 12 bits
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        tick(); in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        check("range_dropped", {31'b0, out_valid}, 32'd0);
        check("range_err", {31'b0, err}, 32'd1);
`else
        check("trunc_imm", {20'b0, inst[31:20]}, 32'h800);
        check("trunc_no_err", {31'b0, err}, 32'd0);
`endif
        tick();

        // Reset to clear any range error before the opcode error check
        rst = 1'b1; tick(); rst = 1'b0;

        // Unsupported opcode
        drive(7'b0000000, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        tick(); in_valid = 1'b0;
        check("badop_no_out", {31'b0, out_valid}, 32'd0);
        check("badop_err", {31'b0, err}, 32'd1);
        tick(); tick();
        check("badop_sticky", {31'b0, err}, 32'd1);

        // Mid-operation reset with queued words
        out_ready = 1'b0;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        tick(); tick(); in_valid = 1'b0;
        check("pre_rst_full", {31'b0, in_ready}, 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b1;
        check("rst_err_clr", {31'b0, err}, 32'd0);
        check("rst_count_clr", {16'b0, count}, 32'd0);
        check("rst_fifo_empty", {31'b0, out_valid}, 32'd0);
        check("rst_inst_zero", inst, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("rst_no_partial", {31'b0, out_valid}, 32'd0);

        // Counter saturation: streaming push+pop, one pop per cycle after the first
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        for (int i = 0; i < 65536; i++) begin
            tick();
        end
        in_valid = 1'b0;
        check("sat_count_max", {16'b0, count}, 32'h0000FFFF);
        tick();
        check("sat_count_hold", {16'b0, count}, 32'h0000FFFF);
        check("sat_drained", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
